i2s_sample_tx: RTL and testbench

//  Transmit end of the mixer audio path. Accepts 16-bit mono mix samples over valid/ready into a small FIFO.

---
 rtl/i2s_sample_tx.sv | 177 +++++++++++++++++
 tb/tb_i2s_sample_tx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx: mono sample FIFO feeding a stereo I2S serialiser.
// Each accepted sample is sent in both the left and the right slot of one frame.
// frame_strobe pulses at every frame start and paces the upstream mixer.
// Compile-time option: define I2S_LEFT_JUSTIFIED_EN for left-justified output
// (no one-BCLK data delay). Without it, the output is standard I2S.
// Handshake: a sample is taken on any clk edge where sample_valid && sample_ready.
module i2s_sample_tx #(
    parameter int CLK_DIV    = 16,
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                underrun_clr,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                frame_strobe,
    output logic                underrun
);

    localparam int FRAME_BITS = 2 * SAMPLE_W;
    localparam int DIV_W      = $clog2(CLK_DIV);
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_RIGHT = BIT_W'(SAMPLE_W);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    // Bit-clock divider state
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             bclk_q, bclk_d;

    // Frame / serialiser state
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  lrclk_q, lrclk_d;
    logic                  sdata_q, sdata_d;
    logic                  strobe_q, strobe_d;
    logic                  underrun_q, underrun_d;
    logic [SAMPLE_W-1:0]   hold_q, hold_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;

    // Sample FIFO state
    logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic div_wrap;
    logic fall;
    logic frame_start;
    logic fifo_empty;
    logic push;
    logic pop;

    assign div_wrap    = (div_cnt_q == DIV_LAST);
    assign fall        = div_wrap && bclk_q;
    assign frame_start = fall && (bit_cnt_q == BIT_LAST);
    assign fifo_empty  = (count_q == '0);
    assign push        = sample_valid && sample_ready;
    assign pop         = frame_start && !fifo_empty;

    // Divider: toggle bclk every CLK_DIV clk cycles
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        bclk_d    = bclk_q;
        if (div_wrap) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
        end
    end

    // FIFO pointers and occupancy; a full FIFO refuses pushes even on a pop cycle
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Serialiser: all frame state advances on bclk falls
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        lrclk_d   = lrclk_q;
        sdata_d   = sdata_q;
        strobe_d  = 1'b0;
        hold_d    = hold_q;
        shift_d   = shift_q;
        if (fall) begin
            bit_cnt_d = frame_start ? '0 : bit_cnt_q + BIT_W'(1);
            lrclk_d   = (bit_cnt_d >= BIT_RIGHT);
            if (frame_start) begin
                strobe_d = 1'b1;
                // An empty FIFO leaves hold_q alone so the last sample repeats
                if (pop) begin
                    hold_d = mem_q[rd_ptr_q];
                end
                shift_d = {hold_d, hold_d};
            end else begin
                shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
            end
`ifdef I2S_LEFT_JUSTIFIED_EN
            // Bit k of the frame goes out in period k
            sdata_d = shift_d[FRAME_BITS-1];
`else
            // Bit k-1 goes out in period k; period 0 finishes the previous frame
            sdata_d = shift_q[FRAME_BITS-1];
`endif
        end
    end

    // Sticky underrun; a new empty frame start overrides a clear in the same cycle
    always_comb begin
        underrun_d = underrun_q;
        if (frame_start && fifo_empty) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end
    end

    // State registers; reset abandons any frame in flight and empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            bclk_q     <= 1'b0;
            bit_cnt_q  <= BIT_LAST;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
            hold_q     <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bclk_q     <= bclk_d;
            bit_cnt_q  <= bit_cnt_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            strobe_q   <= strobe_d;
            underrun_q <= underrun_d;
            hold_q     <= hold_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; validity is tracked by count_q so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    assign sample_ready = (count_q != CNT_FULL);
    assign bclk         = bclk_q;
    assign lrclk        = lrclk_q;
    assign sdata        = sdata_q;
    assign frame_strobe = strobe_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// tb_i2s_sample_tx: directed bench for i2s_sample_tx (CLK_DIV=2, SAMPLE_W=16, FIFO_DEPTH=4).
// Expected frame words are queued by the stimulus; a monitor rebuilds each
// serial frame from sdata at bclk rising edges and compares against the queue.
`timescale 1ns/1ps
module tb_i2s_sample_tx;

  localparam int CLK_DIV = 2;
  localparam int SW      = 16;
  localparam int DEPTH   = 4;
`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam bit LJ = 1'b1;
`else
  localparam bit LJ = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [SW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          underrun_clr = 1'b0;
  logic          sample_ready;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic          frame_strobe;
  logic          underrun;

  i2s_sample_tx #(
    .CLK_DIV    (CLK_DIV),
    .SAMPLE_W   (SW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .underrun_clr (underrun_clr),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .frame_strobe (frame_strobe),
    .underrun     (underrun)
  );

  // ---------------- scoreboard ----------------
  logic [SW-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // ---------------- monitor ----------------
  int          per = -1;
  bit          pend = 1'b0;
  bit          in_frame = 1'b0;
  bit          lr_bad = 1'b0;
  bit          per_bad = 1'b0;
  logic [31:0] fw = '0;
  logic        bclk_prev = 1'b0;
  int          last_rise = -1;
  int          tick = 0;
  int          bidx = 0;

  always @(negedge clk) begin
    logic [SW-1:0] e;
    tick++;
    if (!rst_n) begin
      per = -1; pend = 1'b0; in_frame = 1'b0; lr_bad = 1'b0; per_bad = 1'b0;
      bclk_prev = 1'b0; last_rise = -1;
    end else begin
      if (frame_strobe) pend = 1'b1;
      if (bclk && !bclk_prev) begin
        if (last_rise >= 0 && (tick - last_rise) != 2 * CLK_DIV) per_bad = 1'b1;
        last_rise = tick;
        if (pend) begin
          per = 0;
          pend = 1'b0;
        end else if (per >= 0) begin
          per = (per + 1) % 32;
        end
        if (per >= 0) begin
          if (lrclk !== (per >= SW)) lr_bad = 1'b1;
          bidx = LJ ? per : (per + 31) % 32;
          if (bidx == 0) in_frame = 1'b1;
          if (in_frame) begin
            fw[31-bidx] = sdata;
            if (bidx == 31) begin
              if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("frame_data", fw, {e, e});
                check("frame_timing", {30'd0, lr_bad, per_bad}, 32'd0);
              end
              in_frame = 1'b0;
              lr_bad = 1'b0;
              per_bad = 1'b0;
            end
          end
        end
      end
      bclk_prev = bclk;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_sample(input logic [SW-1:0] v, output bit strobe_at_ready);
    int n;
    @(negedge clk);
    sample_in = v;
    sample_valid = 1'b1;
    n = 0;
    while (!sample_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    strobe_at_ready = frame_strobe;
    if (!sample_ready) fail_timeout("push_ready");
    @(posedge clk);
    #1 sample_valid = 1'b0;
  endtask

  task automatic wait_strobe();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_strobe && n < 300);
    if (!frame_strobe) fail_timeout("frame_strobe");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      fail_timeout("frames_pending");
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bclk"},         {31'd0, bclk},         32'd0);
    check({tag, "_lrclk"},        {31'd0, lrclk},        32'd0);
    check({tag, "_sdata"},        {31'd0, sdata},        32'd0);
    check({tag, "_frame_strobe"}, {31'd0, frame_strobe}, 32'd0);
    check({tag, "_underrun"},     {31'd0, underrun},     32'd0);
    check({tag, "_ready"},        {31'd0, sample_ready}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit sw;
    int n;

    // Reset values
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    // 1) single sample A5F0 goes out in the first frame
    do_reset();
    exp_q.push_back(16'hA5F0);
    push_sample(16'hA5F0, sw);
    wait_strobe();
    check("t1_lrclk_at_strobe", {31'd0, lrclk}, 32'd0);
    check("t1_bclk_at_strobe", {31'd0, bclk}, 32'd0);
    check("t1_underrun", {31'd0, underrun}, 32'd0);
    drain();

    // 2) no pushes: underrun, clear, and set-wins-over-clear
    do_reset();
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    wait_strobe();
    check("t2_underrun_set", {31'd0, underrun}, 32'd1);
    repeat (5) @(negedge clk);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    check("t2_underrun_clr", {31'd0, underrun}, 32'd0);
    repeat (121) @(negedge clk);
    underrun_clr = 1'b1;
    @(negedge clk);
    check("t2_strobe_period", {31'd0, frame_strobe}, 32'd1);
    check("t2_set_wins", {31'd0, underrun}, 32'd1);
    underrun_clr = 1'b0;
    @(negedge clk);
    check("t2_sticky", {31'd0, underrun}, 32'd1);
    drain();

    // 3) five back-to-back pushes: fill, back-pressure, FIFO order
    do_reset();
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h1001);
    exp_q.push_back(16'h2002);
    exp_q.push_back(16'h4004);
    exp_q.push_back(16'h8008);
    exp_q.push_back(16'hF00F);
    wait_strobe();
    push_sample(16'h1001, sw);
    push_sample(16'h2002, sw);
    push_sample(16'h4004, sw);
    push_sample(16'h8008, sw);
    @(negedge clk);
    check("t3_full_ready", {31'd0, sample_ready}, 32'd0);
    push_sample(16'hF00F, sw);
    check("t3_ready_at_pop", {31'd0, sw}, 32'd1);
    drain();

    // 4) one sample then nothing: repeated, underrun on the second frame
    do_reset();
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h1234);
    push_sample(16'h1234, sw);
    wait_strobe();
    check("t4_underrun_f1", {31'd0, underrun}, 32'd0);
    wait_strobe();
    check("t4_underrun_f2", {31'd0, underrun}, 32'd1);
    drain();

    // 5) reset in the right slot with a full FIFO
    do_reset();
    wait_strobe();
    push_sample(16'h1111, sw);
    push_sample(16'h2222, sw);
    push_sample(16'h3333, sw);
    push_sample(16'h4444, sw);
    @(negedge clk);
    check("t5_full_ready", {31'd0, sample_ready}, 32'd0);
    n = 0;
    while (!lrclk && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!lrclk) fail_timeout("t5_right_slot");
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t5");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(16'h0000);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_strobe && n < 50);
    check("t5_first_strobe_cycles", n, 2 * CLK_DIV);
    check("t5_underrun_after_flush", {31'd0, underrun}, 32'd1);
    drain();

    // 6) 8001: only the two extreme bits of each slot set
    do_reset();
    exp_q.push_back(16'h8001);
    push_sample(16'h8001, sw);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
